nes_pad_poller: RTL and testbench

Autonomous sequencer for the NES-style serial game controllers. It periodically generates the latch pulse (`pulse_out`) and shift clock (`cclk`), and samples up to two controller data lines. It publishes debounced-free, active-high button bytes with a one-cycle `valid` strobe to the game logic. It replaces ad-hoc polling inside the game logic, so that `core`/`gamelogic` sees only stable button registers.

---
 rtl/nes_pad_if.sv | 21 ++
 rtl/nes_pad_poller.sv | 134 +++++++++++++
 tb/tb_nes_pad_poller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_if.sv
// nes_pad_if: game-logic side controls, controller pins and button results of nes_pad_poller.
interface nes_pad_if;
    logic       enable;
    logic       poll_now;
    logic       c1_data_in;
    logic       c2_data_in;
    logic       cclk;
    logic       pulse_out;
    logic [7:0] c1_buttons;
    logic [7:0] c2_buttons;
    logic       valid;
    logic       busy;
    modport slave (
        input  enable, poll_now, c1_data_in, c2_data_in,
        output cclk, pulse_out, c1_buttons, c2_buttons, valid, busy
    );
    modport master (
        output enable, poll_now, c1_data_in, c2_data_in,
        input  cclk, pulse_out, c1_buttons, c2_buttons, valid, busy
    );
endinterface

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: periodic latch/shift sequencer for NES serial pads, publishing active-high button bytes.
// Controller 2 sampling is built only when NES_PAD_CTRL2_EN is defined; otherwise c2_buttons reads 8'h00.
module nes_pad_poller #(
    parameter int HALF_PER    = 240,
    parameter int POLL_PERIOD = 666667
) (
    input  logic      clk,
    input  logic      reset_n,
    nes_pad_if.slave  bus
);
    localparam int CW = $clog2(2 * HALF_PER);
    localparam int TW = $clog2(POLL_PERIOD);
    localparam logic [CW-1:0] FULL_END = CW'(2 * HALF_PER - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_PER - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_PER);
    localparam logic [TW-1:0] TMR_END  = TW'(POLL_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      slot_q, slot_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            pend_q, pend_d;
    logic [7:0]      c1_sr_q, c1_sr_d;
    logic [7:0]      c1_btn_q, c1_btn_d;
    logic            cclk_q, cclk_d;
    logic            pulse_q, pulse_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            wrap, req, last;
`ifdef NES_PAD_CTRL2_EN
    logic [7:0]      c2_sr_q, c2_sr_d;
    logic [7:0]      c2_btn_q, c2_btn_d;
`endif

    assign wrap = (tmr_q == TMR_END);
    assign req  = bus.poll_now | (wrap & bus.enable);
    // slot 0 is only the low half; later slots span a full cclk period
    assign last = (slot_q == 3'd0) ? (cnt_q == HALF_END) : (cnt_q == FULL_END);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        tmr_d    = wrap ? '0 : tmr_q + 1'b1;
        pend_d   = pend_q | req;
        c1_sr_d  = c1_sr_q;
`ifdef NES_PAD_CTRL2_EN
        c2_sr_d  = c2_sr_q;
        c2_btn_d = (state_q == DONE) ? c2_sr_q : c2_btn_q;
`endif
        c1_btn_d = (state_q == DONE) ? c1_sr_q : c1_btn_q;
        case (state_q)
            IDLE: if (pend_q) begin
                state_d = LATCH;
                cnt_d   = '0;
                pend_d  = req;
            end
            LATCH: if (cnt_q == FULL_END) begin
                state_d = SHIFT;
                cnt_d   = '0;
                slot_d  = 3'd0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SHIFT: if (last) begin
                c1_sr_d = {c1_sr_q[6:0], ~bus.c1_data_in};
`ifdef NES_PAD_CTRL2_EN
                c2_sr_d = {c2_sr_q[6:0], ~bus.c2_data_in};
`endif
                cnt_d   = '0;
                slot_d  = slot_q + 3'd1;
                state_d = (slot_q == 3'd7) ? DONE : SHIFT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        pulse_d = (state_d == LATCH);
        cclk_d  = (state_d == SHIFT) && (slot_d != 3'd0) && (cnt_d < HALF_CNT);
        busy_d  = (state_d != IDLE);
        valid_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            slot_q   <= '0;
            tmr_q    <= '0;
            pend_q   <= 1'b0;
            c1_sr_q  <= '0;
            c1_btn_q <= '0;
            cclk_q   <= 1'b0;
            pulse_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            tmr_q    <= tmr_d;
            pend_q   <= pend_d;
            c1_sr_q  <= c1_sr_d;
            c1_btn_q <= c1_btn_d;
            cclk_q   <= cclk_d;
            pulse_q  <= pulse_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

`ifdef NES_PAD_CTRL2_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c2_sr_q  <= '0;
            c2_btn_q <= '0;
        end else begin
            c2_sr_q  <= c2_sr_d;
            c2_btn_q <= c2_btn_d;
        end
    end
    assign bus.c2_buttons = c2_btn_q;
`else
    assign bus.c2_buttons = 8'h00;
`endif

    assign bus.cclk       = cclk_q;
    assign bus.pulse_out  = pulse_q;
    assign bus.c1_buttons = c1_btn_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_nes_pad_poller.sv
// tb_nes_pad_poller: directed scenarios for nes_pad_poller with HALF_PER=2, POLL_PERIOD=100.
module tb_nes_pad_poller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;

`ifdef NES_PAD_CTRL2_EN
    localparam logic [7:0] C2_ALL = 8'hFF;
`else
    localparam logic [7:0] C2_ALL = 8'h00;
`endif

    nes_pad_if bus();
    nes_pad_poller #(.HALF_PER(2), .POLL_PERIOD(100)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic start_poll;
        @(negedge clk);
        bus.poll_now = 1'b1;
        @(negedge clk);
        bus.poll_now = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        bus.enable = 1'b0; bus.poll_now = 1'b0; bus.c1_data_in = 1'b1; bus.c2_data_in = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.cclk !== 1'b0) begin fails++; $display("FAIL reset_cclk got %b want 0", bus.cclk); end
        tests++; if (bus.pulse_out !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", bus.pulse_out); end
        tests++; if (bus.c1_buttons !== 8'h00) begin fails++; $display("FAIL reset_c1 got %h want 00", bus.c1_buttons); end
        tests++; if (bus.c2_buttons !== 8'h00) begin fails++; $display("FAIL reset_c2 got %h want 00", bus.c2_buttons); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        reset_n = 1'b1;
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL idle_no_poll got %0d active cycles want 0", n); end
    endtask

    task automatic test_single_poll;
        logic [7:0] pat;
        int b0, vt, np, nr, nh, nv;
        logic pc;
        pat = 8'b0111_1110;
        b0 = -1; vt = -1; np = 0; nr = 0; nh = 0; nv = 0; pc = 1'b0;
        start_poll();
        fork
            begin
                for (int t = 0; t < 80; t++) begin
                    @(negedge clk);
                    if (bus.busy === 1'b1 && b0 < 0) b0 = t;
                    if (bus.pulse_out === 1'b1) np++;
                    if (bus.cclk === 1'b1 && !pc) nr++;
                    if (bus.cclk === 1'b1) nh++;
                    pc = (bus.cclk === 1'b1);
                    if (bus.valid === 1'b1) begin nv++; if (vt < 0) vt = t; end
                end
            end
            begin
                int n;
                n = 0;
                while (bus.pulse_out !== 1'b1 && n < 20) begin @(negedge clk); n++; end
                while (bus.pulse_out === 1'b1 && n < 20) begin @(negedge clk); n++; end
                for (int k = 0; k < 8; k++) begin
                    bus.c1_data_in = pat[k];
                    repeat (4) @(negedge clk);
                end
                bus.c1_data_in = 1'b1;
            end
        join
        tests++; if (b0 != 0) begin fails++; $display("FAIL poll_busy_rise got %0d want 0", b0); end
        tests++; if (np != 4) begin fails++; $display("FAIL poll_pulse_len got %0d want 4", np); end
        tests++; if (nr != 7) begin fails++; $display("FAIL poll_cclk_pulses got %0d want 7", nr); end
        tests++; if (nh != 14) begin fails++; $display("FAIL poll_cclk_high got %0d want 14", nh); end
        tests++; if (vt - b0 != 35) begin fails++; $display("FAIL poll_valid_delay got %0d want 35", vt - b0); end
        tests++; if (nv != 1) begin fails++; $display("FAIL poll_valid_count got %0d want 1", nv); end
        tests++; if (bus.c1_buttons !== 8'h81) begin fails++; $display("FAIL poll_c1 got %h want 81", bus.c1_buttons); end
        tests++; if (bus.c2_buttons !== 8'h00) begin fails++; $display("FAIL poll_c2 got %h want 00", bus.c2_buttons); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL poll_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_enable;
        int v0, v1, nv;
        v0 = -1; v1 = -1; nv = 0;
        bus.c1_data_in = 1'b1; bus.c2_data_in = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 260; t++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                nv++;
                if (v0 < 0) v0 = t; else if (v1 < 0) v1 = t;
            end
        end
        bus.enable = 1'b0;
        repeat (80) @(negedge clk);
        tests++; if (nv < 2) begin fails++; $display("FAIL auto_valid_count got %0d want >=2", nv); end
        tests++; if (v1 - v0 != 100) begin fails++; $display("FAIL auto_period got %0d want 100", v1 - v0); end
        tests++; if (bus.c2_buttons !== C2_ALL) begin fails++; $display("FAIL auto_c2 got %h want %h", bus.c2_buttons, C2_ALL); end
        tests++; if (bus.c1_buttons !== 8'h00) begin fails++; $display("FAIL auto_c1 got %h want 00", bus.c1_buttons); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL auto_stop got %b want 0", bus.busy); end
        bus.c2_data_in = 1'b1;
    endtask

    task automatic test_back_to_back;
        int r0, r1, nr, nv;
        logic pb;
        r0 = -1; r1 = -1; nr = 0; nv = 0; pb = 1'b0;
        start_poll();
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && !pb) begin
                nr++;
                if (r0 < 0) r0 = t; else if (r1 < 0) r1 = t;
            end
            pb = (bus.busy === 1'b1);
            if (bus.valid === 1'b1) nv++;
            bus.poll_now = (t == 10 || t == 20);
        end
        bus.poll_now = 1'b0;
        tests++; if (nr != 2) begin fails++; $display("FAIL b2b_polls got %0d want 2", nr); end
        tests++; if (r1 - r0 != 36) begin fails++; $display("FAIL b2b_restart got %0d want 36", r1 - r0); end
        tests++; if (nv != 2) begin fails++; $display("FAIL b2b_valids got %0d want 2", nv); end
    endtask

    task automatic test_wrap_coincide;
        int nb, rt, nr, nv;
        logic pb;
        nb = -1; rt = -1; nr = 0; nv = 0; pb = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 150 && nb < 0; t++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin nb = t; bus.enable = 1'b0; end
        end
        bus.enable = 1'b0;
        tests++; if (nb < 0) begin fails++; $display("FAIL wrap_first_poll got none want a poll within 150 cycles"); end
        pb = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (t >= 60) begin
                if (bus.busy === 1'b1 && !pb) begin nr++; if (rt < 0) rt = t; end
                if (bus.valid === 1'b1) nv++;
            end
            pb = (bus.busy === 1'b1);
            bus.poll_now = (t == 98);
            bus.enable   = (t == 98);
        end
        bus.poll_now = 1'b0; bus.enable = 1'b0;
        tests++; if (rt != 100) begin fails++; $display("FAIL wrap_start got %0d want 100", rt); end
        tests++; if (nr != 1) begin fails++; $display("FAIL wrap_polls got %0d want 1", nr); end
        tests++; if (nv != 1) begin fails++; $display("FAIL wrap_valids got %0d want 1", nv); end
    endtask

    task automatic test_reset_midpoll;
        int nv;
        nv = 0;
        bus.c1_data_in = 1'b0;
        start_poll();
        repeat (50) @(negedge clk);
        tests++; if (bus.c1_buttons !== 8'hFF) begin fails++; $display("FAIL mid_pre_c1 got %h want ff", bus.c1_buttons); end
        start_poll();
        repeat (20) @(negedge clk);
        tests++; if (bus.cclk !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL mid_slot4 got cclk=%b busy=%b want 1 1", bus.cclk, bus.busy); end
        reset_n = 1'b0;
        #1;
        tests++; if (bus.cclk !== 1'b0) begin fails++; $display("FAIL mid_cclk got %b want 0", bus.cclk); end
        tests++; if (bus.pulse_out !== 1'b0) begin fails++; $display("FAIL mid_pulse got %b want 0", bus.pulse_out); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        tests++; if (bus.c1_buttons !== 8'h00) begin fails++; $display("FAIL mid_c1 got %h want 00", bus.c1_buttons); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.c1_data_in = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) nv++;
        end
        tests++; if (nv != 0) begin fails++; $display("FAIL mid_no_valid got %0d active cycles want 0", nv); end
    endtask

    initial begin
        test_reset();
        test_single_poll();
        test_enable();
        test_back_to_back();
        test_wrap_coincide();
        test_reset_midpoll();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
